// File: rtl/pow2_stream_detect_if.sv
// Stream bundle for pow2_stream_detect: word input handshake plus classified result output.
// Optional ceil-to-power-of-two fields exist only when POW2_ROUNDUP_EN is defined.
interface pow2_stream_detect_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_is_pow2;
    logic             out_zero;
    logic [IDX_W-1:0] out_msb_idx;
    logic [WIDTH-1:0] out_data;
`ifdef POW2_ROUNDUP_EN
    logic [WIDTH-1:0] out_ceil_pow2;
    logic             out_ceil_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_is_pow2, out_zero, out_msb_idx, out_data,
        input  out_ceil_pow2, out_ceil_ovf
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_is_pow2, out_zero, out_msb_idx, out_data,
        output out_ceil_pow2, out_ceil_ovf
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_is_pow2, out_zero, out_msb_idx, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_is_pow2, out_zero, out_msb_idx, out_data
    );
`endif
endinterface

// File: rtl/pow2_stream_detect.sv
// Two-stage streaming power-of-two / MSB-index / zero classifier with saturating pow2 counter.
// Optional macro POW2_ROUNDUP_EN adds ceil-to-power-of-two result with overflow flag.
module pow2_stream_detect #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    pow2_stream_detect_if.slave bus,
    output logic [CNT_W-1:0] pow2_count
);
    localparam int IDX_W = $clog2(WIDTH);

    function automatic logic f_is_pow2(input logic [WIDTH-1:0] w);
        return (w != '0) && ((w & (w - 1'b1)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] f_msb_idx(input logic [WIDTH-1:0] w);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) idx = i[IDX_W-1:0];
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

`ifdef POW2_ROUNDUP_EN
    // Returns {ovf, ceil}; words above the top bit's weight clamp to that weight.
    function automatic logic [WIDTH:0] f_ceil_pow2(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] one;
        logic [WIDTH-1:0] top;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        top = {1'b1, {(WIDTH-1){1'b0}}};
        if (w == '0)      return {1'b0, one};
        if (w > top)      return {1'b1, top};
        if (f_is_pow2(w)) return {1'b0, w};
        return {1'b0, one << (32'(f_msb_idx(w)) + 1)};
    endfunction
`endif

    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] data_p1_q, data_p1_d;
    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] data_p2_q, data_p2_d;
    logic             pow2_p2_q, pow2_p2_d;
    logic             zero_p2_q, zero_p2_d;
    logic [IDX_W-1:0] msb_p2_q, msb_p2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s2_adv;
    logic             in_ready;
`ifdef POW2_ROUNDUP_EN
    logic [WIDTH-1:0] ceil_p2_q, ceil_p2_d;
    logic             ovf_p2_q, ovf_p2_d;
    logic [WIDTH:0]   ceil_res;
`endif

    always_comb begin
        s2_adv    = !vld_p2_q || bus.out_ready;
        in_ready  = !rst && (!vld_p1_q || s2_adv);
        vld_p1_d  = vld_p1_q;
        data_p1_d = data_p1_q;
        vld_p2_d  = vld_p2_q;
        data_p2_d = data_p2_q;
        pow2_p2_d = pow2_p2_q;
        zero_p2_d = zero_p2_q;
        msb_p2_d  = msb_p2_q;
        cnt_d     = cnt_q;
`ifdef POW2_ROUNDUP_EN
        ceil_res  = f_ceil_pow2(data_p1_q);
        ceil_p2_d = ceil_p2_q;
        ovf_p2_d  = ovf_p2_q;
`endif

        // S1: capture the incoming word
        if (bus.in_valid && in_ready) begin
            vld_p1_d  = 1'b1;
            data_p1_d = bus.in_data;
        end else if (s2_adv) begin
            vld_p1_d  = 1'b0;
        end

        // S2: classify the S1 word; held while the consumer stalls
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                data_p2_d = data_p1_q;
                pow2_p2_d = f_is_pow2(data_p1_q);
                zero_p2_d = (data_p1_q == '0);
                msb_p2_d  = f_msb_idx(data_p1_q);
`ifdef POW2_ROUNDUP_EN
                ceil_p2_d = ceil_res[WIDTH-1:0];
                ovf_p2_d  = ceil_res[WIDTH];
`endif
            end
        end

        if (vld_p2_q && bus.out_ready && pow2_p2_q) cnt_d = f_sat_inc(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data registers carry no reset; outputs are masked by the stage valid instead.
    always_ff @(posedge clk) begin
        data_p1_q <= data_p1_d;
        data_p2_q <= data_p2_d;
        pow2_p2_q <= pow2_p2_d;
        zero_p2_q <= zero_p2_d;
        msb_p2_q  <= msb_p2_d;
`ifdef POW2_ROUNDUP_EN
        ceil_p2_q <= ceil_p2_d;
        ovf_p2_q  <= ovf_p2_d;
`endif
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = vld_p2_q;
    assign bus.out_is_pow2 = vld_p2_q & pow2_p2_q;
    assign bus.out_zero    = vld_p2_q & zero_p2_q;
    assign bus.out_msb_idx = vld_p2_q ? msb_p2_q : '0;
    assign bus.out_data    = vld_p2_q ? data_p2_q : '0;
`ifdef POW2_ROUNDUP_EN
    assign bus.out_ceil_pow2 = vld_p2_q ? ceil_p2_q : '0;
    assign bus.out_ceil_ovf  = vld_p2_q & ovf_p2_q;
`endif
    assign pow2_count = cnt_q;

endmodule

// File: tb/tb_pow2_stream_detect.sv
// Directed self-checking bench for pow2_stream_detect (WIDTH=8); a second CNT_W=2 instance checks saturation.
module tb_pow2_stream_detect;
    logic        clk;
    logic        rst;
    logic [15:0] pow2_count;
    logic [1:0]  pow2_count2;
    int          vectors;
    int          miscompares;

    pow2_stream_detect_if #(.WIDTH(8)) bus ();
    pow2_stream_detect_if #(.WIDTH(8)) bus2 ();

    pow2_stream_detect #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pow2_count (pow2_count)
    );

    pow2_stream_detect #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus2),
        .pow2_count (pow2_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] sdat [6] = '{8'd7, 8'd4, 8'd7, 8'd64, 8'd16, 8'd7};
    logic       spow [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] smsb [6] = '{3'd2, 3'd2, 3'd2, 3'd6, 3'd4, 3'd2};
    logic [7:0] edat [3] = '{8'h00, 8'hFF, 8'h80};
    logic       ezer [3] = '{1'b1, 1'b0, 1'b0};
    logic       epow [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0] emsb [3] = '{3'd0, 3'd7, 3'd7};
    logic [7:0] pdat [5] = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd128};
    logic [1:0] pcnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] bdat [3] = '{8'd4, 8'd16, 8'd64};
`ifdef POW2_ROUNDUP_EN
    logic [7:0] cdat [4] = '{8'd0, 8'd5, 8'd64, 8'd200};
    logic [7:0] cexp [4] = '{8'd1, 8'd8, 8'd64, 8'd128};
    logic       cofl [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`endif

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b1;
        repeat (2) step();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_is_pow2", bus.out_is_pow2, 0);
        check("rst_zero", bus.out_zero, 0);
        check("rst_msb_idx", bus.out_msb_idx, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_count", pow2_count, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_count_sat", pow2_count2, 0);
`ifdef POW2_ROUNDUP_EN
        check("rst_ceil", bus.out_ceil_pow2, 0);
        check("rst_ceil_ovf", bus.out_ceil_ovf, 0);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // Back-to-back stream, results appear two cycles after each input
        for (int k = 0; k < 8; k++) begin
            if (k < 2) begin
                check("stream_latency", bus.out_valid, 0);
            end else begin
                check("stream_valid", bus.out_valid, 1);
                check("stream_data", bus.out_data, sdat[k-2]);
                check("stream_is_pow2", bus.out_is_pow2, spow[k-2]);
                check("stream_msb_idx", bus.out_msb_idx, smsb[k-2]);
                check("stream_zero", bus.out_zero, 0);
            end
            if (k < 6) begin
                bus.in_valid = 1'b1;
                bus.in_data  = sdat[k];
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
        end
        step();
        check("stream_drained", bus.out_valid, 0);
        check("stream_count", pow2_count, 3);

        // Edge words: zero, all-ones, top bit
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = edat[k];
            step();
            bus.in_valid = 1'b0;
            step();
            check("edge_valid", bus.out_valid, 1);
            check("edge_zero", bus.out_zero, ezer[k]);
            check("edge_is_pow2", bus.out_is_pow2, epow[k]);
            check("edge_msb_idx", bus.out_msb_idx, emsb[k]);
            step();
        end
        check("edge_count", pow2_count, 4);

        // Backpressure: two accepts, then in_ready drops and the head result holds
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = bdat[0];
        #1;
        check("bp_ready0", bus.in_ready, 1);
        step();
        bus.in_data = bdat[1];
        #1;
        check("bp_ready1", bus.in_ready, 1);
        step();
        bus.in_data = bdat[2];
        #1;
        check("bp_ready_full", bus.in_ready, 0);
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_data", bus.out_data, 4);
        repeat (3) step();
        check("bp_still_full", bus.in_ready, 0);
        check("bp_still_valid", bus.out_valid, 1);
        check("bp_still_data", bus.out_data, 4);
        check("bp_still_pow2", bus.out_is_pow2, 1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check("bp_out1_valid", bus.out_valid, 1);
        check("bp_out1_data", bus.out_data, bdat[1]);
        step();
        check("bp_out2_valid", bus.out_valid, 1);
        check("bp_out2_data", bus.out_data, bdat[2]);
        step();
        check("bp_empty", bus.out_valid, 0);
        check("bp_count", pow2_count, 7);

        // Reset with two words in flight
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd4;
        step();
        bus.in_data  = 8'd16;
        step();
        bus.in_valid = 1'b0;
        check("flight_valid", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_count", pow2_count, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_stale_valid", bus.out_valid, 0);
        end
        check("no_stale_count", pow2_count, 0);

        // Counter saturation on the CNT_W=2 instance
        for (int k = 0; k < 5; k++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = pdat[k];
            step();
            bus2.in_valid = 1'b0;
            step();
            check("sat_pow2", bus2.out_is_pow2, 1);
            step();
            check("sat_count", pow2_count2, pcnt[k]);
        end

`ifdef POW2_ROUNDUP_EN
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = cdat[k];
            step();
            bus.in_valid = 1'b0;
            step();
            check("ceil_value", bus.out_ceil_pow2, cexp[k]);
            check("ceil_ovf", bus.out_ceil_ovf, cofl[k]);
            step();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
